// File: rtl/pixel_median5.sv
// Per-channel min/median/max of 5 RGB pixels using one shared compare-exchange unit
// stepped through a 10-compare odd-even transposition sort; valid/ready on both sides.
package pixel_pkg;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;
endpackage

module pixel_median5 (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  pixel_pkg::pixel_t in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output pixel_pkg::pixel_t out_med,
  output pixel_pkg::pixel_t out_min,
  output pixel_pkg::pixel_t out_max
);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [2:0]        pass_q;
  logic              pair_q;
  logic              in_ready_q;
  logic              out_valid_q;
  pixel_pkg::pixel_t buf_q [5];

  logic [2:0]        lo_idx;
  logic [2:0]        hi_idx;
  pixel_pkg::pixel_t cx_a;
  pixel_pkg::pixel_t cx_b;
  pixel_pkg::pixel_t cx_lo;
  pixel_pkg::pixel_t cx_hi;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? b : a;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Even passes use pairs (0,1),(2,3); odd passes shift by one to (1,2),(3,4).
  always_comb begin
    lo_idx    = {1'b0, pair_q, 1'b0} + {2'b00, pass_q[0]};
    hi_idx    = lo_idx + 3'd1;
    cx_a      = buf_q[lo_idx];
    cx_b      = buf_q[hi_idx];
    cx_lo.red = min8(cx_a.red, cx_b.red);
    cx_lo.grn = min8(cx_a.grn, cx_b.grn);
    cx_lo.blu = min8(cx_a.blu, cx_b.blu);
    cx_hi.red = max8(cx_a.red, cx_b.red);
    cx_hi.grn = max8(cx_a.grn, cx_b.grn);
    cx_hi.blu = max8(cx_a.blu, cx_b.blu);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      pass_q      <= 3'd0;
      pair_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 5; i++) buf_q[i] <= '0;
    end else if (clr) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      pass_q      <= 3'd0;
      pair_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            buf_q[cnt_q] <= in_pix;
            if (cnt_q == 3'd4) begin
              cnt_q      <= 3'd0;
              pass_q     <= 3'd0;
              pair_q     <= 1'b0;
              in_ready_q <= 1'b0;
              state_q    <= SORT;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        SORT: begin
          buf_q[lo_idx] <= cx_lo;
          buf_q[hi_idx] <= cx_hi;
          if (pair_q && pass_q == 3'd4) begin
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (pair_q) begin
            pass_q <= pass_q + 3'd1;
            pair_q <= 1'b0;
          end else begin
            pair_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= 3'd0;
            state_q     <= LOAD;
          end
        end
        default: begin
          state_q     <= LOAD;
          cnt_q       <= 3'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_min   = buf_q[0];
  assign out_med   = buf_q[2];
  assign out_max   = buf_q[4];

endmodule

// File: tb/tb_pixel_median5.sv
// Bench for pixel_median5: group/timing model with a per-channel sort reference,
// checked every cycle, plus hand-computed expectations for each directed scenario.
module tb_pixel_median5;
  logic clk = 1'b0;
  logic rst_n, clr, in_valid, out_valid, out_ready, in_ready;
  pixel_pkg::pixel_t in_pix, out_med, out_min, out_max;

  int checks = 0;
  int errors = 0;

  pixel_median5 dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .out_valid(out_valid), .out_ready(out_ready),
    .out_med(out_med), .out_min(out_min), .out_max(out_max)
  );

  always #5 clk = ~clk;

  // Reference: returns {min, med, max} of five bytes by a plain sort.
  function automatic logic [23:0] mmm(input logic [39:0] v5);
    logic [7:0] v [5];
    logic [7:0] t;
    for (int i = 0; i < 5; i++) v[i] = v5[i*8 +: 8];
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return {v[0], v[2], v[4]};
  endfunction

  // Model phases: 0 collecting, 1 sorting (10 clocks), 2 presenting result.
  int m_phase = 0;
  int m_n = 0;
  int m_timer = 0;
  pixel_pkg::pixel_t m_grp [5];
  pixel_pkg::pixel_t e_min, e_med, e_max;

  always @(posedge clk or negedge rst_n) begin
    logic [39:0] rr, gg, bb;
    logic [23:0] tr, tg, tb;
    if (!rst_n) begin
      m_phase = 0; m_n = 0; m_timer = 0;
    end else if (clr) begin
      m_phase = 0; m_n = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_grp[m_n] = in_pix;
          m_n++;
          if (m_n == 5) begin
            for (int i = 0; i < 5; i++) begin
              rr[i*8 +: 8] = m_grp[i].red;
              gg[i*8 +: 8] = m_grp[i].grn;
              bb[i*8 +: 8] = m_grp[i].blu;
            end
            tr = mmm(rr); tg = mmm(gg); tb = mmm(bb);
            e_min = {tr[23:16], tg[23:16], tb[23:16]};
            e_med = {tr[15:8],  tg[15:8],  tb[15:8]};
            e_max = {tr[7:0],   tg[7:0],   tb[7:0]};
            m_timer = 10;
            m_phase = 1;
          end
        end
        1: begin
          m_timer--;
          if (m_timer == 0) m_phase = 2;
        end
        default: if (out_ready) begin m_phase = 0; m_n = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (in_ready !== (m_phase == 0)) begin
      errors++; $display("FAIL model in_ready: got %b expected %b", in_ready, m_phase == 0);
    end
    checks++;
    if (out_valid !== (m_phase == 2)) begin
      errors++; $display("FAIL model out_valid: got %b expected %b", out_valid, m_phase == 2);
    end
    if (m_phase == 2) begin
      checks++;
      if ({out_min, out_med, out_max} !== {e_min, e_med, e_max}) begin
        errors++;
        $display("FAIL model result: got min %h med %h max %h expected min %h med %h max %h",
                 out_min, out_med, out_max, e_min, e_med, e_max);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int n;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_pix   = {r, g, b};
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) chk("send timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    if (!out_valid) chk("out_valid timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_med", 32'(out_med), 32'd0);
    chk("reset out_min", 32'(out_min), 32'd0);
    chk("reset out_max", 32'(out_max), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single channel with latency measurement
    send(50, 0, 0); send(10, 0, 0); send(40, 0, 0); send(20, 0, 0); send(30, 0, 0);
    wait_out(n);
    chk("s1 latency", 32'(n), 32'd10);
    chk("s1 min red", 32'(out_min.red), 32'd10);
    chk("s1 med red", 32'(out_med.red), 32'd30);
    chk("s1 max red", 32'(out_max.red), 32'd50);

    // Independent channels
    send(1, 9, 5); send(2, 8, 5); send(3, 7, 5); send(4, 6, 5); send(5, 5, 5);
    wait_out(n);
    chk("s2 med", 32'(out_med), 32'h030705);
    chk("s2 min", 32'(out_min), 32'h010505);
    chk("s2 max", 32'(out_max), 32'h050905);

    // Backpressure, with a pixel offered during OUT that must be ignored
    @(posedge clk); #2 out_ready = 1'b0;
    send(9, 1, 200); send(3, 4, 100); send(7, 2, 150); send(5, 8, 50); send(1, 6, 250);
    wait_out(n);
    in_valid = 1'b1; in_pix = {8'd99, 8'd99, 8'd99};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("s3 hold valid", 32'(out_valid), 32'd1);
      chk("s3 hold in_ready", 32'(in_ready), 32'd0);
      chk("s3 hold med", 32'(out_med), 32'h050496);
    end
    chk("s3 min", 32'(out_min), 32'h010132);
    chk("s3 max", 32'(out_max), 32'h0908FA);
    @(posedge clk); #2 out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("s3 valid before handshake", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("s3 in_ready after handshake", 32'(in_ready), 32'd1);
    chk("s3 valid after handshake", 32'(out_valid), 32'd0);

    // Ties and extremes
    for (int i = 0; i < 5; i++) send(255, 0, 128);
    wait_out(n);
    chk("s4 med", 32'(out_med), 32'hFF0080);
    chk("s4 min", 32'(out_min), 32'hFF0080);
    chk("s4 max", 32'(out_max), 32'hFF0080);
    send(0, 1, 0); send(255, 2, 0); send(0, 3, 0); send(255, 4, 0); send(0, 5, 0);
    wait_out(n);
    chk("s4b med red", 32'(out_med.red), 32'd0);
    chk("s4b min red", 32'(out_min.red), 32'd0);
    chk("s4b max red", 32'(out_max.red), 32'd255);

    // clr after three accepts
    send(200, 200, 200); send(200, 200, 200); send(200, 200, 200);
    @(posedge clk); #2 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    send(10, 20, 30); send(50, 40, 60); send(30, 60, 90); send(40, 10, 0); send(20, 30, 45);
    wait_out(n);
    chk("s5a med", 32'(out_med), 32'h1E1E2D);
    chk("s5a min", 32'(out_min), 32'h0A0A00);
    chk("s5a max", 32'(out_max), 32'h323C5A);

    // clr during the fourth SORT cycle
    send(1, 1, 1); send(2, 2, 2); send(3, 3, 3); send(4, 4, 4); send(5, 5, 5);
    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("s5b no out_valid", 32'(seen), 32'd0);
    chk("s5b in_ready", 32'(in_ready), 32'd1);

    // clr coincident with the output handshake
    send(6, 6, 6); send(7, 7, 7); send(8, 8, 8); send(9, 9, 9); send(10, 10, 10);
    wait_out(n);
    clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    @(negedge clk);
    chk("s5c out_valid", 32'(out_valid), 32'd0);
    chk("s5c in_ready", 32'(in_ready), 32'd1);

    // Async reset pulse mid-SORT
    send(1, 9, 5); send(2, 8, 5); send(3, 7, 5); send(4, 6, 5); send(5, 5, 5);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("s6 out_valid", 32'(out_valid), 32'd0);
    chk("s6 in_ready", 32'(in_ready), 32'd1);
    chk("s6 out_med", 32'(out_med), 32'd0);
    chk("s6 out_min", 32'(out_min), 32'd0);
    chk("s6 out_max", 32'(out_max), 32'd0);
    #3 rst_n = 1'b1;
    send(50, 1, 2); send(10, 3, 4); send(40, 5, 6); send(20, 7, 8); send(30, 9, 10);
    wait_out(n);
    chk("s6 post latency", 32'(n), 32'd10);
    chk("s6 post med", 32'(out_med), 32'h1E0506);
    chk("s6 post min", 32'(out_min), 32'h0A0102);
    chk("s6 post max", 32'(out_max), 32'h32090A);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
